// File: rtl/shared_reg_arbiter_pkg.sv
// Shared definitions for the shared-register arbiter: op encodings,
// FSM state encoding and the grant index width helper.
package shared_reg_arbiter_pkg;

  // Operation encodings carried on each requester's op field
  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_INC   = 2'b10;
  localparam logic [1:0] OP_CLR   = 2'b11;

  // Transaction FSM states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_ACK  = 2'd2,
    ST_REL  = 2'd3
  } state_t;

  // Width of an index that selects one of n requesters (at least one bit)
  function automatic int gid_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_rr_picker.sv
// Combinational circular priority picker: returns the first asserted
// request at or after the pointer, wrapping around the request vector.
module rr_picker
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = gid_width(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] winner,
  output logic          any
);

  int idx;

  // Scan requesters starting at ptr; the first asserted one wins
  always_comb begin
    winner = '0;
    any    = 1'b0;
    idx    = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!any && req[idx]) begin
        winner = IW'(idx);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter serialising req/ack transactions from NREQ
// requesters onto one shared WD-bit working register.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int WD   = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NREQ-1:0]           req,
  input  logic [2*NREQ-1:0]         op,
  input  logic [WD*NREQ-1:0]        wdata,
  output logic [NREQ-1:0]           ack,
  output logic [WD-1:0]             rdata,
  output logic [$clog2(NREQ)-1:0]   grant_id,
  output logic                      busy
);

  localparam int IW = gid_width(NREQ);

  state_t          state_q, state_d;
  logic [WD-1:0]   reg_q, reg_d;
  logic [WD-1:0]   rdata_q, rdata_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [1:0]      op_q, op_d;
  logic [WD-1:0]   wdata_q, wdata_d;

  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic [IW-1:0]   ptr_next;

  rr_picker #(
    .N  (NREQ),
    .IW (IW)
  ) u_picker (
    .req    (req),
    .ptr    (ptr_q),
    .winner (pick_idx),
    .any    (pick_any)
  );

  // Pointer moves to the requester just after the one being released
  always_comb begin
    ptr_next = (grant_q == IW'(NREQ - 1)) ? '0 : grant_q + IW'(1);
  end

  // Next-state logic: grant in IDLE, commit in EXEC, hold ack until release
  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    rdata_d = rdata_q;
    ack_d   = ack_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    op_d    = op_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          op_d    = op[2*int'(pick_idx) +: 2];
          wdata_d = wdata[WD*int'(pick_idx) +: WD];
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (op_q)
          OP_READ:  reg_d = reg_q;
          OP_WRITE: reg_d = wdata_q;
          OP_INC:   reg_d = reg_q + WD'(1);
          default:  reg_d = '0;
        endcase
        rdata_d          = reg_d;
        ack_d            = '0;
        ack_d[grant_q]   = 1'b1;
        state_d          = ST_ACK;
      end
      ST_ACK: begin
        if (!req[grant_q]) begin
          ack_d   = '0;
          ptr_d   = ptr_next;
          state_d = ST_REL;
        end
      end
      ST_REL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, register, pointer and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      reg_q   <= '0;
      rdata_q <= '0;
      ack_q   <= '0;
      grant_q <= '0;
      ptr_q   <= '0;
      op_q    <= OP_READ;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      op_q    <= op_d;
      wdata_q <= wdata_d;
    end
  end

  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign grant_id = grant_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Self-checking bench for shared_reg_arbiter: a scoreboard of expected
// (requester, value) pairs is filled as requests are driven and drained
// whenever an ack rises.
module tb_shared_reg_arbiter;
  import shared_reg_arbiter_pkg::*;

  localparam int NREQ = 4;
  localparam int WD   = 4;

  typedef struct {
    int         id;
    logic [3:0] val;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NREQ-1:0]  req;
  logic [2*NREQ-1:0] op;
  logic [WD*NREQ-1:0] wdata;
  logic [NREQ-1:0]  ack;
  logic [WD-1:0]    rdata;
  logic [1:0]       grant_id;
  logic             busy;

  int         errors = 0;
  int         checks = 0;
  int         grant_events = 0;
  logic [3:0] prev_ack;
  logic [3:0] model_reg;
  logic       auto_rel;
  logic [3:0] hog;
  exp_t       sbq[$];

  shared_reg_arbiter #(
    .NREQ (NREQ),
    .WD   (WD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .op       (op),
    .wdata    (wdata),
    .ack      (ack),
    .rdata    (rdata),
    .grant_id (grant_id),
    .busy     (busy)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Hard stop in case something unexpected blocks the main sequence
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Apply one op to the reference register and queue the expected ack
  task automatic push_exp(input int id, input logic [1:0] o, input logic [3:0] d);
    exp_t e;
    case (o)
      OP_READ:  model_reg = model_reg;
      OP_WRITE: model_reg = d;
      OP_INC:   model_reg = model_reg + 4'd1;
      default:  model_reg = 4'd0;
    endcase
    e.id  = id;
    e.val = model_reg;
    sbq.push_back(e);
  endtask

  // Drive one requester's op and write data fields
  task automatic set_port(input int id, input logic [1:0] o, input logic [3:0] d);
    op[2*id +: 2]    = o;
    wdata[4*id +: 4] = d;
  endtask

  // Advance one cycle; on the falling edge check any new ack against the
  // scoreboard, then let requesters release or re-request
  task automatic tick();
    exp_t e;
    int   aid;
    @(posedge clk);
    @(negedge clk);
    if (ack !== 4'b0000 && prev_ack === 4'b0000) begin
      grant_events++;
      aid = -1;
      for (int i = 0; i < NREQ; i++) if (ack[i] === 1'b1) aid = i;
      checks++;
      if (!$onehot(ack)) begin
        errors++;
        $display("[TB] FAIL ack_onehot: ack=%b required exactly one bit", ack);
      end
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_ack: ack=%b with no pending expectation", ack);
      end else begin
        e = sbq.pop_front();
        checks += 3;
        if (aid !== e.id) begin
          errors++;
          $display("[TB] FAIL ack_id: got %0d expected %0d", aid, e.id);
        end
        if (rdata !== e.val) begin
          errors++;
          $display("[TB] FAIL rdata: got %h expected %h (req %0d)", rdata, e.val, e.id);
        end
        if (grant_id !== 2'(e.id)) begin
          errors++;
          $display("[TB] FAIL grant_id: got %0d expected %0d", grant_id, e.id);
        end
      end
    end
    prev_ack = ack;
    if (auto_rel) req = req & ~ack;
    for (int i = 0; i < NREQ; i++)
      if (hog[i] && !req[i] && !ack[i]) req[i] = 1'b1;
  endtask

  // Run until all expected acks are seen and the arbiter is idle again
  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (!(sbq.size() == 0 && busy === 1'b0 && req === 4'b0000) && n < budget) begin
      tick();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("[TB] FAIL %s_timeout: pending=%0d busy=%b req=%b required all done",
               name, sbq.size(), busy, req);
      sbq.delete();
      req = '0;
    end
  endtask

  // One complete 4-phase transaction from a single requester
  task automatic run_txn(input int id, input logic [1:0] o, input logic [3:0] d, input string name);
    push_exp(id, o, d);
    set_port(id, o, d);
    auto_rel = 1'b1;
    req[id]  = 1'b1;
    wait_done(40, name);
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick();
    tick();
    checks += 4;
    if (ack !== 4'b0)    begin errors++; $display("[TB] FAIL reset_ack: got %b expected 0000", ack); end
    if (rdata !== 4'h0)  begin errors++; $display("[TB] FAIL reset_rdata: got %h expected 0", rdata); end
    if (grant_id !== 2'd0) begin errors++; $display("[TB] FAIL reset_grant: got %0d expected 0", grant_id); end
    if (busy !== 1'b0)   begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    rst_n = 1'b1;
    tick();
    run_txn(0, OP_WRITE, 4'h9, "reset_prep");
    set_port(2, OP_WRITE, 4'h5);
    req[2] = 1'b1;
    tick();
    checks += 2;
    if (busy !== 1'b1)     begin errors++; $display("[TB] FAIL exec_busy: got %b expected 1", busy); end
    if (grant_id !== 2'd2) begin errors++; $display("[TB] FAIL exec_grant: got %0d expected 2", grant_id); end
    rst_n = 1'b0;
    req   = '0;
    #1;
    checks += 4;
    if (ack !== 4'b0)    begin errors++; $display("[TB] FAIL midreset_ack: got %b expected 0000", ack); end
    if (rdata !== 4'h0)  begin errors++; $display("[TB] FAIL midreset_rdata: got %h expected 0", rdata); end
    if (grant_id !== 2'd0) begin errors++; $display("[TB] FAIL midreset_grant: got %0d expected 0", grant_id); end
    if (busy !== 1'b0)   begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
    prev_ack  = 4'b0;
    model_reg = 4'h0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_busy: got %b expected 0", busy); end
    run_txn(1, OP_READ, 4'h0, "post_reset_read");
  endtask

  task automatic test_single_write();
    auto_rel = 1'b0;
    push_exp(0, OP_WRITE, 4'hA);
    set_port(0, OP_WRITE, 4'hA);
    req[0] = 1'b1;
    tick();
    checks++;
    if (ack !== 4'b0000) begin errors++; $display("[TB] FAIL early_ack: got %b expected 0000", ack); end
    tick();
    checks += 2;
    if (ack !== 4'b0001) begin errors++; $display("[TB] FAIL write_ack: got %b expected 0001", ack); end
    if (rdata !== 4'hA)  begin errors++; $display("[TB] FAIL write_rdata: got %h expected a", rdata); end
    req[0] = 1'b0;
    tick();
    checks += 2;
    if (ack !== 4'b0000) begin errors++; $display("[TB] FAIL ack_fall: got %b expected 0000", ack); end
    if (busy !== 1'b1)   begin errors++; $display("[TB] FAIL rel_busy: got %b expected 1", busy); end
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_busy: got %b expected 0", busy); end
    run_txn(2, OP_READ, 4'h0, "read_back");
  endtask

  task automatic test_inc_wrap();
    run_txn(3, OP_WRITE, 4'hF, "write_f");
    run_txn(1, OP_INC, 4'h0, "inc_wrap");
    run_txn(3, OP_READ, 4'h0, "read_zero");
  endtask

  task automatic test_round_robin();
    push_exp(0, OP_WRITE, 4'h3);
    push_exp(1, OP_INC, 4'h0);
    push_exp(2, OP_READ, 4'h0);
    push_exp(3, OP_INC, 4'h0);
    set_port(0, OP_WRITE, 4'h3);
    set_port(1, OP_INC, 4'h0);
    set_port(2, OP_READ, 4'h0);
    set_port(3, OP_INC, 4'h0);
    auto_rel = 1'b1;
    req = 4'b1111;
    wait_done(100, "rr_all");
    push_exp(1, OP_CLR, 4'h0);
    push_exp(3, OP_WRITE, 4'h7);
    set_port(1, OP_CLR, 4'h0);
    set_port(3, OP_WRITE, 4'h7);
    req = 4'b1010;
    wait_done(60, "rr_pair");
  endtask

  task automatic test_early_release();
    int ack1_cycles;
    int other_cycles;
    ack1_cycles  = 0;
    other_cycles = 0;
    push_exp(1, OP_WRITE, 4'h6);
    push_exp(2, OP_READ, 4'h0);
    set_port(1, OP_WRITE, 4'h6);
    set_port(2, OP_READ, 4'h0);
    auto_rel = 1'b1;
    req[1] = 1'b1;
    req[2] = 1'b1;
    tick();
    req[1] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (ack[1] === 1'b1) ack1_cycles++;
      if ((ack & 4'b1101) !== 4'b0000) other_cycles++;
    end
    checks += 2;
    if (ack1_cycles != 1) begin
      errors++;
      $display("[TB] FAIL early_ack_len: got %0d cycles expected 1", ack1_cycles);
    end
    if (other_cycles != 0) begin
      errors++;
      $display("[TB] FAIL early_other_ack: got %0d cycles expected 0", other_cycles);
    end
    wait_done(50, "early_release");
  endtask

  task automatic test_starvation();
    int   start;
    int   before3;
    logic seen3;
    run_txn(3, OP_READ, 4'h0, "starve_prep");
    for (int i = 0; i < NREQ; i++) begin
      push_exp(i, OP_READ, 4'h0);
      set_port(i, OP_READ, 4'h0);
    end
    start    = grant_events;
    before3  = -1;
    seen3    = 1'b0;
    auto_rel = 1'b1;
    hog      = 4'b0111;
    req      = 4'b1111;
    for (int k = 0; k < 100 && !seen3; k++) begin
      tick();
      if (ack[3] === 1'b1) begin
        seen3    = 1'b1;
        before3  = grant_events - start - 1;
        hog      = 4'b0000;
        req[2:0] = 3'b000;
      end
    end
    hog = 4'b0000;
    checks += 2;
    if (!seen3) begin
      errors++;
      $display("[TB] FAIL starve_grant: req3 ack seen=%b expected 1", seen3);
      req = '0;
      sbq.delete();
    end
    if (before3 < 0 || before3 > 3) begin
      errors++;
      $display("[TB] FAIL starve_bound: got %0d grants before req3 expected at most 3", before3);
    end
    wait_done(50, "starvation");
  endtask

  // Main sequence
  initial begin
    rst_n     = 1'b1;
    req       = '0;
    op        = '0;
    wdata     = '0;
    prev_ack  = 4'b0;
    model_reg = 4'h0;
    auto_rel  = 1'b1;
    hog       = 4'b0;
    test_reset();
    test_single_write();
    test_inc_wrap();
    test_round_robin();
    test_early_release();
    test_starvation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
